arp_tx_sched: RTL and testbench

Scheduler for the single ARP transmit builder in the UDP stack. Arbitrates between reply requests from the ARP receive path (remote host asked for our MAC) and outgoing request generation (IP cache miss from the UDP transmit side). Sequences the builder with a start/done handshake, returns the reply acknowledge to the receive path, and retries unanswered requests on a timer until they resolve or exhaust their retry budget.

---
 rtl/arp_tx_sched.sv | 157 +++++++++++++++
 tb/tb_arp_tx_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_tx_sched.sv
// ARP transmit scheduler: round-robin between replies and request generation,
// builder start/done sequencing, and timed request retries with a retry budget.
module arp_tx_sched #(
    parameter int RETRY_CYCLES = 125000000,
    parameter int MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        reply_req_in,
    input  logic [31:0] reply_ip_in,
    input  logic [47:0] reply_mac_in,
    output logic        reply_ack_out,
    input  logic        lookup_req_in,
    input  logic [31:0] lookup_ip_in,
    input  logic        resolved_in,
    input  logic [31:0] resolved_ip_in,
    output logic        lookup_fail_out,
    input  logic        tx_ready_in,
    output logic        tx_start_out,
    output logic [15:0] tx_opcode_out,
    output logic [31:0] tx_target_ip_out,
    output logic [47:0] tx_target_mac_out,
    input  logic        tx_done_in,
    output logic        busy_out
);
    localparam int              TW         = $clog2(RETRY_CYCLES);
    localparam logic [TW-1:0]   TIMER_LOAD = TW'(RETRY_CYCLES - 1);
    localparam logic [3:0]      MAX_CNT    = 4'(MAX_RETRY);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t        state_q;
    logic          gnt_reply_q, last_reply_q, reply_req_q, reply_ack_q, tx_start_q;
    logic [15:0]   opcode_q;
    logic [31:0]   tgt_ip_q;
    logic [47:0]   tgt_mac_q;

    logic          req_pend_q, req_pend_d, send_due_q, send_due_d, inflight_q, inflight_d;
    logic [31:0]   req_ip_q, req_ip_d;
    logic [3:0]    retry_cnt_q, retry_cnt_d;
    logic [TW-1:0] timer_q, timer_d;

    logic reply_elig, req_elig, grant_any, grant_reply, grant_req;
    logic resolve_hit, expire, give_up, done_req;

    // Reply request is sampled so a fresh reply starts two cycles after it rises.
    assign reply_elig  = reply_req_q & ~reply_ack_q;
    assign req_elig    = req_pend_q & send_due_q;
    assign grant_any   = (state_q == IDLE) & tx_ready_in & (reply_elig | req_elig);
    assign grant_reply = reply_elig & (~req_elig | ~last_reply_q);
    assign grant_req   = grant_any & ~grant_reply;
    assign resolve_hit = resolved_in & req_pend_q & (resolved_ip_in == req_ip_q);
    assign expire      = req_pend_q & ~send_due_q & (timer_q == '0);
    assign give_up     = expire & (retry_cnt_q == MAX_CNT) & ~resolve_hit;
    // inflight_q ties a done back to the lookup that launched it, so a frame
    // outliving a resolved lookup cannot charge a newer one.
    assign done_req    = (state_q == WAIT) & tx_done_in & ~gnt_reply_q & inflight_q;

    always_comb begin
        req_pend_d  = req_pend_q;
        req_ip_d    = req_ip_q;
        retry_cnt_d = retry_cnt_q;
        send_due_d  = send_due_q;
        inflight_d  = inflight_q;
        timer_d     = timer_q;
        if (!req_pend_q && lookup_req_in) begin
            req_pend_d  = 1'b1;
            req_ip_d    = lookup_ip_in;
            retry_cnt_d = '0;
            send_due_d  = 1'b1;
            inflight_d  = 1'b0;
            timer_d     = '0;
        end else if (resolve_hit || give_up) begin
            req_pend_d = 1'b0;
            send_due_d = 1'b0;
            inflight_d = 1'b0;
        end else begin
            if (grant_req)
                inflight_d = 1'b1;
            if (done_req) begin
                retry_cnt_d = retry_cnt_q + 4'd1;
                send_due_d  = 1'b0;
                inflight_d  = 1'b0;
                timer_d     = TIMER_LOAD;
            end else if (expire) begin
                send_due_d = 1'b1;
            end else if (req_pend_q && !send_due_q) begin
                timer_d = timer_q - TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_pend_q  <= 1'b0;
            req_ip_q    <= '0;
            retry_cnt_q <= '0;
            send_due_q  <= 1'b0;
            inflight_q  <= 1'b0;
            timer_q     <= '0;
        end else begin
            req_pend_q  <= req_pend_d;
            req_ip_q    <= req_ip_d;
            retry_cnt_q <= retry_cnt_d;
            send_due_q  <= send_due_d;
            inflight_q  <= inflight_d;
            timer_q     <= timer_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            gnt_reply_q  <= 1'b0;
            last_reply_q <= 1'b0;
            reply_req_q  <= 1'b0;
            reply_ack_q  <= 1'b0;
            tx_start_q   <= 1'b0;
            opcode_q     <= '0;
            tgt_ip_q     <= '0;
            tgt_mac_q    <= '0;
        end else begin
            reply_req_q <= reply_req_in;
            if (!reply_req_in)
                reply_ack_q <= 1'b0;
            case (state_q)
                IDLE: if (grant_any) begin
                    state_q     <= START;
                    tx_start_q  <= 1'b1;
                    gnt_reply_q <= grant_reply;
                    opcode_q    <= grant_reply ? 16'd2 : 16'd1;
                    tgt_ip_q    <= grant_reply ? reply_ip_in : req_ip_q;
                    tgt_mac_q   <= grant_reply ? reply_mac_in : 48'd0;
                end
                START: begin
                    tx_start_q <= 1'b0;
                    state_q    <= WAIT;
                end
                WAIT: if (tx_done_in) begin
                    state_q      <= IDLE;
                    last_reply_q <= gnt_reply_q;
                    if (gnt_reply_q)
                        reply_ack_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign reply_ack_out     = reply_ack_q;
    assign lookup_fail_out   = give_up;
    assign tx_start_out      = tx_start_q;
    assign tx_opcode_out     = opcode_q;
    assign tx_target_ip_out  = tgt_ip_q;
    assign tx_target_mac_out = tgt_mac_q;
    assign busy_out          = (state_q != IDLE);
endmodule

// File: tb/tb_arp_tx_sched.sv
// Directed bench for arp_tx_sched: expected frames are queued as stimulus is
// driven and popped by a monitor on every tx_start_out.
module tb_arp_tx_sched;
    localparam int RC = 16;
    localparam int MR = 3;

    logic        clk = 0;
    logic        reset_n = 0;
    logic        reply_req_in = 0;
    logic [31:0] reply_ip_in = 0;
    logic [47:0] reply_mac_in = 0;
    logic        reply_ack_out;
    logic        lookup_req_in = 0;
    logic [31:0] lookup_ip_in = 0;
    logic        resolved_in = 0;
    logic [31:0] resolved_ip_in = 0;
    logic        lookup_fail_out;
    logic        tx_ready_in = 1;
    logic        tx_start_out;
    logic [15:0] tx_opcode_out;
    logic [31:0] tx_target_ip_out;
    logic [47:0] tx_target_mac_out;
    logic        tx_done_in = 0;
    logic        busy_out;

    arp_tx_sched #(.RETRY_CYCLES(RC), .MAX_RETRY(MR)) dut (
        .clk(clk), .reset_n(reset_n),
        .reply_req_in(reply_req_in), .reply_ip_in(reply_ip_in), .reply_mac_in(reply_mac_in),
        .reply_ack_out(reply_ack_out),
        .lookup_req_in(lookup_req_in), .lookup_ip_in(lookup_ip_in),
        .resolved_in(resolved_in), .resolved_ip_in(resolved_ip_in),
        .lookup_fail_out(lookup_fail_out),
        .tx_ready_in(tx_ready_in), .tx_start_out(tx_start_out), .tx_opcode_out(tx_opcode_out),
        .tx_target_ip_out(tx_target_ip_out), .tx_target_mac_out(tx_target_mac_out),
        .tx_done_in(tx_done_in), .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] op;
        logic [31:0] ip;
        logic [47:0] mac;
    } exp_t;

    exp_t exp_q[$];
    int   start_cyc[$];
    int   done_cyc[$];
    int   fail_cyc[$];
    int   cyc = 0;
    int   nstarts = 0;
    int   nfails = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [15:0] op, input logic [31:0] ip, input logic [47:0] mac);
        exp_t e;
        e.op = op; e.ip = ip; e.mac = mac;
        exp_q.push_back(e);
    endtask

    task automatic wait_starts(input int n);
        int t = 0;
        while (nstarts < n && t < 300) begin step(1); t++; end
        checks++;
        assert (nstarts >= n) else begin
            errors++;
            $error("FAIL wait_starts observed=%0d expected=%0d", nstarts, n);
        end
    endtask

    task automatic wait_done(input int n);
        int t = 0;
        while (done_cyc.size() < n && t < 300) begin step(1); t++; end
        checks++;
        assert (done_cyc.size() >= n) else begin
            errors++;
            $error("FAIL wait_done observed=%0d expected=%0d", done_cyc.size(), n);
        end
    endtask

    task automatic lookup(input logic [31:0] ip);
        lookup_req_in = 1; lookup_ip_in = ip;
        step(1);
        lookup_req_in = 0;
    endtask

    task automatic resolve(input logic [31:0] ip);
        resolved_in = 1; resolved_ip_in = ip;
        step(1);
        resolved_in = 0;
    endtask

    // Scoreboard monitor: every start must match the oldest queued frame.
    initial forever begin
        @(negedge clk);
        if (reset_n && tx_start_out) begin
            nstarts++;
            start_cyc.push_back(cyc);
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_start observed=ip %0h expected=no start", tx_target_ip_out);
            end
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("opcode", 64'(tx_opcode_out), 64'(e.op));
                chk("target_ip", 64'(tx_target_ip_out), 64'(e.ip));
                chk("target_mac", 64'(tx_target_mac_out), 64'(e.mac));
            end
        end
        if (lookup_fail_out) begin nfails++; fail_cyc.push_back(cyc); end
        if (tx_done_in) done_cyc.push_back(cyc);
    end

    // Builder model: done two cycles after each start.
    initial forever begin
        @(negedge clk);
        if (tx_start_out) begin
            step(2);
            tx_done_in = 1;
            step(1);
            tx_done_in = 0;
        end
    end

    initial begin
        int n, sb, db, fb;
        step(3);
        chk("rst_start", 64'(tx_start_out), 0);
        chk("rst_ack", 64'(reply_ack_out), 0);
        chk("rst_fail", 64'(lookup_fail_out), 0);
        chk("rst_busy", 64'(busy_out), 0);
        chk("rst_opcode", 64'(tx_opcode_out), 0);
        chk("rst_mac", 64'(tx_target_mac_out), 0);
        reset_n = 1;
        step(2);

        // Single reply
        sb = nstarts; db = done_cyc.size();
        push(16'd2, 32'hC0A80102, 48'h001122334455);
        reply_ip_in = 32'hC0A80102; reply_mac_in = 48'h001122334455; reply_req_in = 1;
        n = cyc;
        wait_starts(sb + 1);
        chk("reply_start_lat", 64'(start_cyc[sb] - n), 2);
        wait_done(db + 1);
        chk("reply_ack_set", 64'(reply_ack_out), 1);
        step(5);
        chk("reply_no_restart", 64'(nstarts), 64'(sb + 1));
        chk("reply_ack_hold", 64'(reply_ack_out), 1);
        reply_req_in = 0;
        chk("reply_ack_until_sampled", 64'(reply_ack_out), 1);
        step(1);
        chk("reply_ack_clear", 64'(reply_ack_out), 0);
        step(3);

        // Unanswered lookup with an ignored second lookup
        sb = nstarts; db = done_cyc.size(); fb = nfails;
        repeat (3) push(16'd1, 32'hC0A80105, 48'd0);
        n = cyc;
        lookup(32'hC0A80105);
        step(2);
        lookup(32'hC0A80109);
        begin
            int t = 0;
            while (nfails == fb && t < 300) begin step(1); t++; end
        end
        step(30);
        chk("retry_starts", 64'(nstarts - sb), 3);
        chk("retry_first_lat", 64'(start_cyc[sb] - n), 2);
        chk("retry_gap1", 64'(start_cyc[sb+1] - done_cyc[db]), 64'(RC + 2));
        chk("retry_gap2", 64'(start_cyc[sb+2] - done_cyc[db+1]), 64'(RC + 2));
        chk("fail_pulses", 64'(nfails - fb), 1);
        chk("fail_lat", 64'(fail_cyc[fb] - done_cyc[db+2]), 64'(RC));
        chk("retry_idle", 64'(busy_out), 0);

        // Resolve: wrong IP keeps retrying, matching IP stops it
        sb = nstarts; db = done_cyc.size(); fb = nfails;
        push(16'd1, 32'hC0A80105, 48'd0);
        lookup(32'hC0A80105);
        wait_starts(sb + 1);
        wait_done(db + 1);
        step(5);
        push(16'd1, 32'hC0A80105, 48'd0);
        resolve(32'hC0A80106);
        wait_starts(sb + 2);
        chk("resolve_other_gap", 64'(start_cyc[sb+1] - done_cyc[db]), 64'(RC + 2));
        wait_done(db + 2);
        step(5);
        resolve(32'hC0A80105);
        step(40);
        chk("resolved_no_start", 64'(nstarts), 64'(sb + 2));
        chk("resolved_no_fail", 64'(nfails), 64'(fb));

        // Contention: last grant was a request, so reply goes first
        sb = nstarts;
        tx_ready_in = 0;
        reply_ip_in = 32'hC0A80120; reply_mac_in = 48'hAABBCCDDEE01; reply_req_in = 1;
        lookup(32'hC0A8010A);
        step(3);
        push(16'd2, 32'hC0A80120, 48'hAABBCCDDEE01);
        push(16'd1, 32'hC0A8010A, 48'd0);
        tx_ready_in = 1;
        wait_starts(sb + 2);
        step(4);
        chk("contend_ack", 64'(reply_ack_out), 1);
        reply_req_in = 0;
        step(2);
        // Solo reply so the last grant becomes a reply
        push(16'd2, 32'hC0A80121, 48'hAABBCCDDEE02);
        reply_ip_in = 32'hC0A80121; reply_mac_in = 48'hAABBCCDDEE02; reply_req_in = 1;
        wait_starts(sb + 3);
        step(3);
        tx_ready_in = 0;
        reply_req_in = 0;
        step(2);
        reply_ip_in = 32'hC0A80122; reply_mac_in = 48'hAABBCCDDEE03; reply_req_in = 1;
        step(30);
        push(16'd1, 32'hC0A8010A, 48'd0);
        push(16'd2, 32'hC0A80122, 48'hAABBCCDDEE03);
        tx_ready_in = 1;
        wait_starts(sb + 5);
        resolve(32'hC0A8010A);
        wait_done(done_cyc.size() + 0);
        step(3);
        chk("contend2_ack", 64'(reply_ack_out), 1);
        reply_req_in = 0;
        step(3);

        // Reset during WAIT
        sb = nstarts; db = done_cyc.size(); fb = nfails;
        push(16'd2, 32'hC0A80130, 48'h0000AABB0001);
        reply_ip_in = 32'hC0A80130; reply_mac_in = 48'h0000AABB0001; reply_req_in = 1;
        wait_starts(sb + 1);
        wait_done(db + 1);
        step(2);
        chk("pre_reset_ack", 64'(reply_ack_out), 1);
        push(16'd1, 32'hC0A80140, 48'd0);
        lookup(32'hC0A80140);
        wait_starts(sb + 2);
        chk("pre_reset_busy", 64'(busy_out), 1);
        reset_n = 0;
        #1;
        chk("mid_rst_ack", 64'(reply_ack_out), 0);
        chk("mid_rst_busy", 64'(busy_out), 0);
        chk("mid_rst_opcode", 64'(tx_opcode_out), 0);
        chk("mid_rst_ip", 64'(tx_target_ip_out), 0);
        chk("mid_rst_mac", 64'(tx_target_mac_out), 0);
        chk("mid_rst_start", 64'(tx_start_out), 0);
        reply_req_in = 0;
        step(2);
        reset_n = 1;
        step(40);
        chk("post_rst_no_start", 64'(nstarts), 64'(sb + 2));
        chk("post_rst_no_fail", 64'(nfails), 64'(fb));
        chk("sb_drained", 64'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
